// File: rtl/ring_interlock_scheduler.sv
// Round-robin grant scheduler for an 8-node ring: ring-adjacent nodes are never granted together,
// and every release is followed by a fixed all-grants-low guard interval.
module ring_interlock_scheduler #(
  parameter int TIMEOUT = 255,
  parameter int GUARD   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [7:0] i_req,
  input  logic [7:0] i_done,
  output logic [7:0] o_grant,
  output logic       o_busy,
  output logic [2:0] o_ptr,
  output logic       o_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_HOLD  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  state_t     r_state, w_state;
  logic [7:0] r_grant, w_grant;
  logic [2:0] r_ptr, w_ptr;
  logic       r_busy, w_busy;
  logic       r_fault, w_fault;
  logic [7:0] r_hcnt, w_hcnt;
  logic [3:0] r_gcnt, w_gcnt;

  logic [7:0] w_sel;
  logic [2:0] w_first;
  logic       w_found;
  logic [2:0] w_idx;
  logic [7:0] w_remain;

  // Greedy pass starting at the round-robin pointer; a node is taken only if both ring
  // neighbours are still free, so the first requesting node in scan order always wins.
  always_comb begin
    w_sel   = '0;
    w_first = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (i_req[w_idx] && !w_sel[w_idx - 3'd1] && !w_sel[w_idx + 3'd1]) begin
        w_sel[w_idx] = 1'b1;
        if (!w_found) begin
          w_first = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_remain = r_grant & ~i_done;

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_ptr   = r_ptr;
    w_fault = 1'b0;
    w_hcnt  = r_hcnt;
    w_gcnt  = r_gcnt;
    case (r_state)
      S_IDLE: begin
        w_grant = '0;
        if (i_enable && (i_req != 8'h00)) w_state = S_SCAN;
      end
      S_SCAN: begin
        w_grant = '0;
        if (!i_enable || (i_req == 8'h00)) begin
          w_state = S_IDLE;
        end else begin
          w_grant = w_sel;
          w_ptr   = w_first + 3'd1;
          w_hcnt  = '0;
          w_state = S_HOLD;
        end
      end
      S_HOLD: begin
        // Completion is checked first so a last release coinciding with timeout is not a fault.
        if (w_remain == 8'h00) begin
          w_grant = '0;
          w_gcnt  = '0;
          w_state = S_GUARD;
        end else if (!i_enable) begin
          w_grant = '0;
          w_gcnt  = '0;
          w_state = S_GUARD;
        end else if (r_hcnt == 8'(TIMEOUT - 1)) begin
          w_grant = '0;
          w_fault = 1'b1;
          w_gcnt  = '0;
          w_state = S_GUARD;
        end else begin
          w_grant = w_remain;
          w_hcnt  = r_hcnt + 8'd1;
        end
      end
      S_GUARD: begin
        w_grant = '0;
        if (r_gcnt == 4'(GUARD - 1)) begin
          w_gcnt  = '0;
          w_state = S_IDLE;
        end else begin
          w_gcnt = r_gcnt + 4'd1;
        end
      end
      default: begin
        w_grant = '0;
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
      r_hcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_ptr   <= w_ptr;
      r_busy  <= w_busy;
      r_fault <= w_fault;
      r_hcnt  <= w_hcnt;
      r_gcnt  <= w_gcnt;
    end
  end

  assign o_grant = r_grant;
  assign o_ptr   = r_ptr;
  assign o_busy  = r_busy;
  assign o_fault = r_fault;

endmodule

// File: tb/tb_ring_interlock_scheduler.sv
// Directed bench for ring_interlock_scheduler: cycle-by-cycle vector table plus
// hand-written timeout, completion/timeout race and asynchronous reset sequences.
module tb_ring_interlock_scheduler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] grant;
  logic       busy;
  logic [2:0] ptr;
  logic       fault;

  int n_tests;
  int n_fail;

  ring_interlock_scheduler #(.TIMEOUT(4), .GUARD(2)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_req    (req),
    .i_done   (done),
    .o_grant  (grant),
    .o_busy   (busy),
    .o_ptr    (ptr),
    .o_fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [7:0] rq;
    logic [7:0] dn;
    logic [7:0] exp_grant;
    logic [2:0] exp_ptr;
    logic       exp_busy;
    logic       exp_fault;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eg, input logic [2:0] ep,
                           input logic eb, input logic ef);
    check({tag, ".grant"}, grant, eg);
    check({tag, ".ptr"}, {5'd0, ptr}, {5'd0, ep});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
    check({tag, ".fault"}, {7'd0, fault}, {7'd0, ef});
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic en, input logic [7:0] rq, input logic [7:0] dn);
    enable = en;
    req    = rq;
    done   = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    req     = 8'h00;
    done    = 8'h00;

    //            en    req    done   grant  ptr  busy  fault
    tbl.push_back({1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0}); // IDLE->SCAN
    tbl.push_back({1'b1, 8'hFF, 8'h00, 8'h55, 3'd1, 1'b1, 1'b0}); // FF from ptr 0 -> 55
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h55, 3'd1, 1'b1, 1'b0}); // req drop keeps grant
    tbl.push_back({1'b1, 8'hFF, 8'hAA, 8'h55, 3'd1, 1'b1, 1'b0}); // ungranted done ignored, no new grants
    tbl.push_back({1'b1, 8'h00, 8'hFF, 8'h00, 3'd1, 1'b1, 1'b0}); // all done -> GUARD
    tbl.push_back({1'b1, 8'hFF, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0}); // GUARD 2nd cycle
    tbl.push_back({1'b1, 8'hFF, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0}); // IDLE
    tbl.push_back({1'b1, 8'hFF, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0}); // SCAN
    tbl.push_back({1'b1, 8'hFF, 8'h00, 8'hAA, 3'd2, 1'b1, 1'b0}); // FF from ptr 1 -> AA
    tbl.push_back({1'b1, 8'h00, 8'hAA, 8'h00, 3'd2, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd2, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0});
    tbl.push_back({1'b1, 8'h40, 8'h00, 8'h00, 3'd2, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h40, 8'h00, 8'h40, 3'd7, 1'b1, 1'b0}); // G alone -> ptr 7
    tbl.push_back({1'b1, 8'h00, 8'h40, 8'h00, 3'd7, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd7, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0});
    tbl.push_back({1'b1, 8'h81, 8'h00, 8'h00, 3'd7, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h81, 8'h00, 8'h80, 3'd0, 1'b1, 1'b0}); // A blocked by H wrap
    tbl.push_back({1'b1, 8'h00, 8'h80, 8'h00, 3'd0, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    tbl.push_back({1'b1, 8'h05, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h05, 8'h00, 8'h05, 3'd1, 1'b1, 1'b0}); // grant 05
    tbl.push_back({1'b1, 8'h05, 8'h01, 8'h04, 3'd1, 1'b1, 1'b0}); // partial release
    tbl.push_back({1'b1, 8'h05, 8'h04, 8'h00, 3'd1, 1'b1, 1'b0}); // last release -> GUARD
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0}); // IDLE after 2 guard cycles
    tbl.push_back({1'b1, 8'h01, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0}); // SCAN
    tbl.push_back({1'b1, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0}); // req gone in SCAN -> IDLE, ptr kept
    tbl.push_back({1'b0, 8'hFF, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0}); // disabled stays IDLE
    tbl.push_back({1'b1, 8'h08, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0});
    tbl.push_back({1'b1, 8'h08, 8'h00, 8'h08, 3'd4, 1'b1, 1'b0}); // D alone -> ptr 4
    tbl.push_back({1'b0, 8'h08, 8'h00, 8'h00, 3'd4, 1'b1, 1'b0}); // disable in HOLD, no fault
    tbl.push_back({1'b0, 8'h00, 8'h00, 8'h00, 3'd4, 1'b1, 1'b0});
    tbl.push_back({1'b0, 8'h00, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0});

    #12;
    check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].rq, tbl[i].dn);
      check_all($sformatf("vec%0d", i), tbl[i].exp_grant, tbl[i].exp_ptr,
                tbl[i].exp_busy, tbl[i].exp_fault);
    end

    // Timeout: A granted from ptr 4, held 4 HOLD cycles with no release.
    step(1'b1, 8'h01, 8'h00);
    step(1'b1, 8'h01, 8'h00);
    check_all("to.grant", 8'h01, 3'd1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1, 8'h01, 8'h00);
    check_all("to.held", 8'h01, 3'd1, 1'b1, 1'b0);
    step(1'b1, 8'h00, 8'h00);
    check_all("to.fire", 8'h00, 3'd1, 1'b1, 1'b1);
    step(1'b1, 8'h00, 8'h00);
    check_all("to.pulse", 8'h00, 3'd1, 1'b1, 1'b0);
    step(1'b1, 8'h00, 8'h00);
    check_all("to.idle", 8'h00, 3'd1, 1'b0, 1'b0);

    // Last release on the timeout cycle: completion wins, no fault.
    step(1'b1, 8'h01, 8'h00);
    step(1'b1, 8'h01, 8'h00);
    check_all("race.grant", 8'h01, 3'd1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1, 8'h01, 8'h00);
    step(1'b1, 8'h01, 8'h01);
    check_all("race.end", 8'h00, 3'd1, 1'b1, 1'b0);
    step(1'b1, 8'h00, 8'h00);
    step(1'b1, 8'h00, 8'h00);
    check_all("race.idle", 8'h00, 3'd1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of HOLD with grant 11.
    step(1'b1, 8'h11, 8'h00);
    step(1'b1, 8'h11, 8'h00);
    check_all("rst.pre", 8'h11, 3'd5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst.async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'hFF, 8'h00);
    step(1'b1, 8'hFF, 8'h00);
    check_all("rst.resume", 8'h55, 3'd1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Ring exclusion must hold at every sample point.
  always @(negedge clk) begin
    if (rst_n && ((grant & {grant[0], grant[7:1]}) != 8'h00)) begin
      n_tests++;
      n_fail++;
      $display("FAIL adjacency: grant %02h has ring-adjacent bits", grant);
    end
  end

endmodule
